// File: rtl/jogo_memoria_param.sv
// Parametrised Simon-style memory game: replays a growing sequence on the LEDs, then checks presses.
// Optional feature: define JOGO_TIMEOUT_EN to enable the per-press timeout and FIM_TIMEOUT state.
module jogo_memoria_param #(
  parameter int unsigned N_BOTOES  = 4,
  parameter int unsigned PROF      = 16,
  parameter int unsigned T_LED     = 1000,
  parameter int unsigned T_TIMEOUT = 5000,
  localparam int unsigned AW       = $clog2(PROF)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic [N_BOTOES-1:0] botoes,
  input  logic                mem_we,
  input  logic [AW-1:0]       mem_addr,
  input  logic [N_BOTOES-1:0] mem_dado,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic                timeout,
  output logic [AW-1:0]       db_rodada,
  output logic [AW-1:0]       db_endereco,
  output logic [3:0]          db_estado
);

  localparam int unsigned LW = $clog2(T_LED);

  typedef enum logic [3:0] {
    StInicial    = 4'h0,
    StPrepara    = 4'h1,
    StMostra     = 4'h2,
    StApaga      = 4'h3,
    StProxLed    = 4'h4,
    StEspera     = 4'h5,
    StCompara    = 4'h6,
    StProxJog    = 4'h7,
    StProxRod    = 4'h8,
    StFimAcerto  = 4'hA,
    StFimErro    = 4'hE,
    StFimTimeout = 4'hF
  } estado_e;

  estado_e               estado_q, estado_d;
  logic [AW-1:0]         rodada_q, rodada_d;
  logic [AW-1:0]         endereco_q, endereco_d;
  logic [LW-1:0]         led_cnt_q, led_cnt_d;
  logic [N_BOTOES-1:0]   jogada_q, jogada_d;
  logic                  botao_ant_q, botao_ant_d;
  logic [N_BOTOES-1:0]   leds_q, leds_d;
  logic                  ganhou_q, ganhou_d;
  logic                  perdeu_q, perdeu_d;
  logic                  pronto_q, pronto_d;
  logic [N_BOTOES-1:0]   mem_q [PROF];

  logic                  evento;
  logic                  fim;
  logic                  led_fim;
  logic                  ultimo_passo;
  logic                  rodada_max;
  logic [N_BOTOES-1:0]   mem_rd;

`ifdef JOGO_TIMEOUT_EN
  localparam int unsigned TW = $clog2(T_TIMEOUT);
  logic [TW-1:0]         to_cnt_q, to_cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  to_fim;
  assign to_fim = (to_cnt_q == TW'(T_TIMEOUT - 1));
`else
  logic                  unused_cfg;
  assign unused_cfg = ^T_TIMEOUT;
`endif

  // A press event is the rising edge of "any button down"; holding never retriggers.
  assign evento       = (|botoes) & ~botao_ant_q;
  assign fim          = (estado_q == StFimAcerto) || (estado_q == StFimErro) ||
                        (estado_q == StFimTimeout);
  assign led_fim      = (led_cnt_q == LW'(T_LED - 1));
  assign ultimo_passo = (endereco_q == rodada_q);
  assign rodada_max   = (rodada_q == AW'(PROF - 1));
  assign mem_rd       = mem_q[endereco_q];
  assign botao_ant_d  = |botoes;

  always_comb begin
    estado_d   = estado_q;
    rodada_d   = rodada_q;
    endereco_d = endereco_q;
    led_cnt_d  = '0;
    jogada_d   = jogada_q;
`ifdef JOGO_TIMEOUT_EN
    to_cnt_d   = '0;
`endif
    case (estado_q)
      StInicial: begin
        if (jogar) estado_d = StPrepara;
      end
      StPrepara: begin
        rodada_d   = '0;
        endereco_d = '0;
        jogada_d   = '0;
        estado_d   = StMostra;
      end
      StMostra: begin
        if (led_fim) estado_d = StApaga;
        else         led_cnt_d = led_cnt_q + LW'(1);
      end
      StApaga: begin
        if (!led_fim) begin
          led_cnt_d = led_cnt_q + LW'(1);
        end else if (ultimo_passo) begin
          endereco_d = '0;
          estado_d   = StEspera;
        end else begin
          estado_d = StProxLed;
        end
      end
      StProxLed: begin
        endereco_d = endereco_q + AW'(1);
        estado_d   = StMostra;
      end
      StEspera: begin
`ifdef JOGO_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TW'(1);
`endif
        // A press in the same cycle the timer expires wins.
        if (evento) begin
          jogada_d = botoes;
          estado_d = StCompara;
        end
`ifdef JOGO_TIMEOUT_EN
        else if (to_fim) begin
          estado_d = StFimTimeout;
        end
`endif
      end
      StCompara: begin
        if (jogada_q != mem_rd) estado_d = StFimErro;
        else if (!ultimo_passo) estado_d = StProxJog;
        else if (rodada_max)    estado_d = StFimAcerto;
        else                    estado_d = StProxRod;
      end
      StProxJog: begin
        endereco_d = endereco_q + AW'(1);
        estado_d   = StEspera;
      end
      StProxRod: begin
        rodada_d   = rodada_q + AW'(1);
        endereco_d = '0;
        estado_d   = StMostra;
      end
      StFimAcerto, StFimErro, StFimTimeout: begin
        if (jogar) estado_d = StPrepara;
      end
      default: estado_d = StInicial;
    endcase
  end

  // Outputs are decoded from the current state and registered, so they lag state by one cycle.
  always_comb begin
    leds_d   = (estado_q == StMostra) ? mem_rd : '0;
    ganhou_d = (estado_q == StFimAcerto);
    perdeu_d = (estado_q == StFimErro) || (estado_q == StFimTimeout);
    pronto_d = fim;
  end

`ifdef JOGO_TIMEOUT_EN
  assign timeout_d = (estado_q == StFimTimeout);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= StInicial;
      rodada_q    <= '0;
      endereco_q  <= '0;
      led_cnt_q   <= '0;
      jogada_q    <= '0;
      botao_ant_q <= 1'b0;
      leds_q      <= '0;
      ganhou_q    <= 1'b0;
      perdeu_q    <= 1'b0;
      pronto_q    <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      estado_q    <= estado_d;
      rodada_q    <= rodada_d;
      endereco_q  <= endereco_d;
      led_cnt_q   <= led_cnt_d;
      jogada_q    <= jogada_d;
      botao_ant_q <= botao_ant_d;
      leds_q      <= leds_d;
      ganhou_q    <= ganhou_d;
      perdeu_q    <= perdeu_d;
      pronto_q    <= pronto_d;
`ifdef JOGO_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  // Sequence storage is not reset so a pattern survives a game abort.
  always_ff @(posedge clock) begin
    if (mem_we && ((estado_q == StInicial) || fim)) begin
      mem_q[mem_addr] <= mem_dado;
    end
  end

  assign leds        = leds_q;
  assign ganhou      = ganhou_q;
  assign perdeu      = perdeu_q;
  assign pronto      = pronto_q;
  assign db_rodada   = rodada_q;
  assign db_endereco = endereco_q;
  assign db_estado   = estado_q;
`ifdef JOGO_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Bench for jogo_memoria_param: random sequences and press timing against a game-rule model.
module tb_jogo_memoria_param;

  localparam int unsigned NB   = 4;
  localparam int unsigned PROF = 4;
  localparam int unsigned TL   = 4;
  localparam int unsigned TT   = 20;
  localparam int unsigned AW   = 2;

  logic          clock = 1'b0;
  logic          reset, jogar, mem_we;
  logic [NB-1:0] botoes, mem_dado, leds;
  logic [AW-1:0] mem_addr, db_rodada, db_endereco;
  logic          ganhou, perdeu, pronto, timeout;
  logic [3:0]    db_estado;

  int checks = 0;
  int errors = 0;
  logic [NB-1:0] seq [PROF];

  jogo_memoria_param #(
    .N_BOTOES (NB),
    .PROF     (PROF),
    .T_LED    (TL),
    .T_TIMEOUT(TT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .jogar      (jogar),
    .botoes     (botoes),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_dado   (mem_dado),
    .leds       (leds),
    .ganhou     (ganhou),
    .perdeu     (perdeu),
    .pronto     (pronto),
    .timeout    (timeout),
    .db_rodada  (db_rodada),
    .db_endereco(db_endereco),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  function automatic logic [NB-1:0] rand_onehot();
    logic [NB-1:0] v;
    v = '0;
    v[$urandom_range(NB-1, 0)] = 1'b1;
    return v;
  endfunction

  task automatic load(input int first);
    for (int a = first; a < PROF; a++) begin
      mem_we   = 1'b1;
      mem_addr = AW'(a);
      mem_dado = seq[a];
      cyc();
    end
    mem_we = 1'b0;
  endtask

  task automatic start();
    jogar = 1'b1;
    cyc();
    chk("prepara", db_estado, 4'h1);
    jogar = 1'b0;
    cyc();
    chk("mostra_entry", db_estado, 4'h2);
    chk("clr_ganhou", ganhou, 1'b0);
    chk("clr_perdeu", perdeu, 1'b0);
    chk("clr_pronto", pronto, 1'b0);
    chk("clr_timeout", timeout, 1'b0);
    chk("clr_leds", leds, '0);
    chk("clr_rodada", db_rodada, '0);
    chk("clr_endereco", db_endereco, '0);
  endtask

  // Expected LED trace: each step lit T cycles, dark T cycles, one dark cycle between steps.
  task automatic playback(input int r);
    logic [NB-1:0] exp_q[$];
    for (int j = 0; j <= r; j++) begin
      repeat (TL) exp_q.push_back(seq[j]);
      repeat (TL) exp_q.push_back('0);
      if (j < r) exp_q.push_back('0);
    end
    foreach (exp_q[i]) begin
      cyc();
      chk("leds_play", leds, exp_q[i]);
    end
    chk("espera_entry", db_estado, 4'h5);
    chk("espera_addr", db_endereco, '0);
  endtask

  task automatic end_flags(input logic [3:0] code);
    cyc();
    chk("fim_state", db_estado, code);
    chk("fim_pronto", pronto, 1'b1);
    chk("fim_ganhou", ganhou, code == 4'hA);
    chk("fim_perdeu", perdeu, code != 4'hA);
    chk("fim_timeout", timeout, code == 4'hF);
    chk("fim_leds", leds, '0);
  endtask

  // One full game; press (err_r, err_j) is replaced by bad, corrupt writes memory during playback,
  // and the first press of round hold_r is held for 10 cycles.
  task automatic play(input int err_r, input int err_j, input logic [NB-1:0] bad,
                      input bit corrupt, input int hold_r);
    logic [NB-1:0] v;
    start();
    for (int r = 0; r < PROF; r++) begin
      if (corrupt && r == 0) begin
        mem_we   = 1'b1;
        mem_addr = '0;
        mem_dado = ~seq[0];
      end
      playback(r);
      mem_we = 1'b0;
      for (int j = 0; j <= r; j++) begin
        repeat ($urandom_range(3, 0)) begin
          cyc();
          chk("idle_espera", db_estado, 4'h5);
        end
        v = (r == err_r && j == err_j) ? bad : seq[j];
        botoes = v;
        cyc();
        chk("compara", db_estado, 4'h6);
        chk("cmp_endereco", db_endereco, j);
        chk("cmp_rodada", db_rodada, r);
        if (v !== seq[j]) begin
          botoes = '0;
          cyc();
          chk("erro", db_estado, 4'hE);
          end_flags(4'hE);
          return;
        end
        if (r == hold_r && j == 0 && j < r) begin
          cyc();
          chk("hold_proxjog", db_estado, 4'h7);
          repeat (8) begin
            cyc();
            chk("hold_no_event", db_estado, 4'h5);
          end
          botoes = '0;
          cyc();
          chk("hold_release", db_estado, 4'h5);
        end else begin
          botoes = '0;
          cyc();
          if (j < r) begin
            chk("proxjog", db_estado, 4'h7);
            cyc();
            chk("espera_again", db_estado, 4'h5);
          end else if (r == PROF - 1) begin
            chk("acerto", db_estado, 4'hA);
            end_flags(4'hA);
            chk("acerto_rodada", db_rodada, PROF - 1);
          end else begin
            chk("proxrod", db_estado, 4'h8);
            cyc();
            chk("mostra_next", db_estado, 4'h2);
          end
        end
      end
    end
  endtask

  initial begin
    int er, ej;
    reset    = 1'b1;
    jogar    = 1'b0;
    botoes   = '0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dado = '0;
    seq[0] = 4'b0001;
    seq[1] = 4'b0010;
    seq[2] = 4'b0100;
    seq[3] = 4'b1000;
    cyc();
    // Write during reset must still land.
    mem_we   = 1'b1;
    mem_addr = '0;
    mem_dado = seq[0];
    cyc();
    mem_we = 1'b0;
    chk("rst_leds", leds, '0);
    chk("rst_ganhou", ganhou, 1'b0);
    chk("rst_perdeu", perdeu, 1'b0);
    chk("rst_pronto", pronto, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_estado", db_estado, 4'h0);
    chk("rst_rodada", db_rodada, '0);
    chk("rst_endereco", db_endereco, '0);
    reset = 1'b0;
    load(1);

    // Full win, fixed sequence.
    play(PROF, 0, '0, 1'b0, -1);
    // Wrong second press of round 1, restarting from FIM_ACERTO.
    play(1, 1, 4'b0100, 1'b0, -1);
    // Random sequence, memory write attempted during playback, held button in round 2.
    for (int a = 0; a < PROF; a++) seq[a] = rand_onehot();
    load(0);
    play(PROF, 0, '0, 1'b1, 2);
    // Two-button press is an error; held button in round 1.
    for (int a = 0; a < PROF; a++) seq[a] = rand_onehot();
    load(0);
    play(2, 1, 4'b0011, 1'b0, 1);
    // Random games with a random (or no) wrong press.
    for (int g = 0; g < 4; g++) begin
      for (int a = 0; a < PROF; a++) seq[a] = rand_onehot();
      load(0);
      er = $urandom_range(PROF, 0);
      ej = (er < PROF) ? $urandom_range(er, 0) : 0;
      play(er, ej, {seq[ej][NB-2:0], seq[ej][NB-1]}, 1'b0, -1);
    end

`ifdef JOGO_TIMEOUT_EN
    start();
    playback(0);
    repeat (TT - 1) begin
      cyc();
      chk("to_wait", db_estado, 4'h5);
    end
    cyc();
    chk("to_fire", db_estado, 4'hF);
    end_flags(4'hF);
    start();
    playback(0);
    repeat (TT - 1) begin
      cyc();
      chk("to_wait2", db_estado, 4'h5);
    end
    botoes = seq[0];
    cyc();
    chk("to_press_wins", db_estado, 4'h6);
`else
    start();
    playback(0);
    repeat (TT + 10) begin
      cyc();
      chk("no_to_wait", db_estado, 4'h5);
      chk("no_to_flag", timeout, 1'b0);
    end
    botoes = seq[0];
    cyc();
    chk("no_to_press", db_estado, 4'h6);
`endif
    botoes = '0;
    cyc();
    chk("r0_proxrod", db_estado, 4'h8);
    cyc();
    chk("r1_mostra", db_estado, 4'h2);
    cyc();
    chk("r1_led0", leds, seq[0]);
    // Abort mid-playback.
    reset = 1'b1;
    cyc();
    chk("abort_estado", db_estado, 4'h0);
    chk("abort_leds", leds, '0);
    chk("abort_rodada", db_rodada, '0);
    chk("abort_endereco", db_endereco, '0);
    reset = 1'b0;
    cyc();
    cyc();
    chk("abort_idle", db_estado, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
